// File: rtl/z80_io_port_hub.sv
// Z80 I/O bus front-end: synchronises the port strobes, decodes per-channel port windows and
// runs a single-cycle request / ack handshake with timeout and bus-release tracking.
module z80_io_port_hub #(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned SUB_BITS    = 2,
   parameter logic [NUM_CH*(ADDR_W-SUB_BITS)-1:0] CH_BASE = {6'h27, 6'h26},
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ACK_TIMEOUT = 31
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     A,
   input  logic                  iorq_n,
   input  logic                  rd_n,
   input  logic                  wr_n,
   input  logic [7:0]            cd_in,
   output logic [7:0]            cd_out,
   output logic                  cd_oe,
   output logic                  cs_n,
   output logic [NUM_CH-1:0]     ch_req,
   output logic                  ch_wr,
   output logic [SUB_BITS-1:0]   ch_sub,
   output logic [7:0]            ch_wdata,
   input  logic [NUM_CH*8-1:0]   ch_rdata,
   input  logic [NUM_CH-1:0]     ch_ack,
   output logic                  timeout
);

   localparam int unsigned DEC_W = ADDR_W - SUB_BITS;
   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DRIVE,
      ST_RELEASE
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] iorq_sync_q, iorq_sync_d;
   logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
   logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
   logic                   acc_prev_q, acc_prev_d;
   logic [IDX_W-1:0]       ch_idx_q, ch_idx_d;
   logic                   ch_wr_q, ch_wr_d;
   logic [SUB_BITS-1:0]    ch_sub_q, ch_sub_d;
   logic [7:0]             ch_wdata_q, ch_wdata_d;
   logic [NUM_CH-1:0]      ch_req_q, ch_req_d;
   logic [7:0]             cd_out_q, cd_out_d;
   logic                   cd_oe_q, cd_oe_d;
   logic                   cs_n_q, cs_n_d;
   logic                   timeout_q, timeout_d;
   logic [CNT_W-1:0]       tmo_cnt_q, tmo_cnt_d;
   logic                   ack_pend_q, ack_pend_d;
   logic                   rel_q, rel_d;

   logic                   iorq_s, rd_s, wr_s;
   logic                   s_rd, s_wr, acc_edge;
   logic                   dec_match;
   logic [IDX_W-1:0]       dec_idx;
   logic                   ack_sel;
   logic [7:0]             rdata_sel;
   logic                   released;

   assign iorq_s   = iorq_sync_q[SYNC_STAGES-1];
   assign rd_s     = rd_sync_q[SYNC_STAGES-1];
   assign wr_s     = wr_sync_q[SYNC_STAGES-1];
   assign s_rd     = ~iorq_s & ~rd_s & wr_s;
   assign s_wr     = ~iorq_s & ~wr_s & rd_s;
   assign acc_edge = (s_rd | s_wr) & ~acc_prev_q;

   // Window decode; scanning downwards lets the lowest matching index win.
   always_comb begin
      dec_match = 1'b0;
      dec_idx   = '0;
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
         if (A[ADDR_W-1:SUB_BITS] == CH_BASE[i*DEC_W +: DEC_W]) begin
            dec_match = 1'b1;
            dec_idx   = IDX_W'(i);
         end
      end
   end

   // Ack and read data of the channel that owns the access in flight.
   always_comb begin
      ack_sel   = 1'b0;
      rdata_sel = 8'hFF;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (ch_idx_q == IDX_W'(i)) begin
            ack_sel   = ch_ack[i];
            rdata_sel = ch_rdata[i*8 +: 8];
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      iorq_sync_d = {iorq_sync_q[SYNC_STAGES-2:0], iorq_n};
      rd_sync_d   = {rd_sync_q[SYNC_STAGES-2:0], rd_n};
      wr_sync_d   = {wr_sync_q[SYNC_STAGES-2:0], wr_n};
      acc_prev_d  = s_rd | s_wr;
      ch_idx_d    = ch_idx_q;
      ch_wr_d     = ch_wr_q;
      ch_sub_d    = ch_sub_q;
      ch_wdata_d  = ch_wdata_q;
      ch_req_d    = '0;
      cd_out_d    = cd_out_q;
      cd_oe_d     = cd_oe_q;
      cs_n_d      = cs_n_q;
      timeout_d   = 1'b0;
      tmo_cnt_d   = tmo_cnt_q;
      ack_pend_d  = ack_pend_q;
      rel_d       = rel_q;
      released    = rel_q | iorq_s;

      case (state_q)
         ST_IDLE: begin
            rel_d      = 1'b0;
            ack_pend_d = 1'b0;
            if (acc_edge) begin
               if (dec_match) begin
                  state_d    = ST_REQ;
                  ch_idx_d   = dec_idx;
                  ch_wr_d    = s_wr;
                  ch_sub_d   = A[SUB_BITS-1:0];
                  ch_wdata_d = cd_in;
                  cs_n_d     = 1'b0;
                  ch_req_d   = NUM_CH'(1) << dec_idx;
               end else begin
                  state_d = ST_RELEASE;
               end
            end
         end

         ST_REQ: begin
            state_d    = ST_WAIT;
            tmo_cnt_d  = CNT_W'(ACK_TIMEOUT);
            ack_pend_d = ack_sel;
            rel_d      = iorq_s;
         end

         // An early strobe release finishes the access without touching the data bus.
         ST_WAIT: begin
            rel_d     = released;
            tmo_cnt_d = tmo_cnt_q - CNT_W'(1);
            if (ack_sel | ack_pend_q) begin
               if (released) begin
                  state_d = ST_IDLE;
                  cs_n_d  = 1'b1;
               end else if (ch_wr_q) begin
                  state_d = ST_RELEASE;
               end else begin
                  state_d  = ST_DRIVE;
                  cd_out_d = rdata_sel;
                  cd_oe_d  = s_rd;
               end
            end else if (tmo_cnt_q == CNT_W'(1)) begin
               timeout_d = 1'b1;
               if (released) begin
                  state_d = ST_IDLE;
                  cs_n_d  = 1'b1;
               end else if (ch_wr_q) begin
                  state_d = ST_RELEASE;
               end else begin
                  state_d  = ST_DRIVE;
                  cd_out_d = 8'hFF;
                  cd_oe_d  = s_rd;
               end
            end
         end

         ST_DRIVE: begin
            if (s_rd) begin
               cd_oe_d = 1'b1;
            end else begin
               cd_oe_d = 1'b0;
               state_d = ST_RELEASE;
            end
         end

         ST_RELEASE: begin
            if (iorq_s) begin
               state_d = ST_IDLE;
               cs_n_d  = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cs_n_d  = 1'b1;
            cd_oe_d = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         iorq_sync_q <= '1;
         rd_sync_q   <= '1;
         wr_sync_q   <= '1;
         acc_prev_q  <= 1'b0;
         ch_idx_q    <= '0;
         ch_wr_q     <= 1'b0;
         ch_sub_q    <= '0;
         ch_wdata_q  <= 8'h00;
         ch_req_q    <= '0;
         cd_out_q    <= 8'hFF;
         cd_oe_q     <= 1'b0;
         cs_n_q      <= 1'b1;
         timeout_q   <= 1'b0;
         tmo_cnt_q   <= '0;
         ack_pend_q  <= 1'b0;
         rel_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         iorq_sync_q <= iorq_sync_d;
         rd_sync_q   <= rd_sync_d;
         wr_sync_q   <= wr_sync_d;
         acc_prev_q  <= acc_prev_d;
         ch_idx_q    <= ch_idx_d;
         ch_wr_q     <= ch_wr_d;
         ch_sub_q    <= ch_sub_d;
         ch_wdata_q  <= ch_wdata_d;
         ch_req_q    <= ch_req_d;
         cd_out_q    <= cd_out_d;
         cd_oe_q     <= cd_oe_d;
         cs_n_q      <= cs_n_d;
         timeout_q   <= timeout_d;
         tmo_cnt_q   <= tmo_cnt_d;
         ack_pend_q  <= ack_pend_d;
         rel_q       <= rel_d;
      end
   end

   assign cd_out   = cd_out_q;
   assign cd_oe    = cd_oe_q;
   assign cs_n     = cs_n_q;
   assign ch_req   = ch_req_q;
   assign ch_wr    = ch_wr_q;
   assign ch_sub   = ch_sub_q;
   assign ch_wdata = ch_wdata_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_z80_io_port_hub.sv
// Directed bench for z80_io_port_hub: default two-channel instance plus a four-channel
// instance with overlapping windows and a permanently asserted ack.
module tb_z80_io_port_hub;

   logic        clk;
   logic        reset_n;
   logic [7:0]  A;
   logic        iorq_n, rd_n, wr_n;
   logic [7:0]  cd_in;
   logic [7:0]  cd_out;
   logic        cd_oe, cs_n;
   logic [1:0]  ch_req;
   logic        ch_wr;
   logic [1:0]  ch_sub;
   logic [7:0]  ch_wdata;
   logic [15:0] ch_rdata;
   logic [1:0]  ch_ack;
   logic        timeout;

   logic [7:0]  cd_out4;
   logic        cd_oe4, cs_n4, ch_wr4, timeout4;
   logic [3:0]  ch_req4;
   logic [1:0]  ch_sub4;
   logic [7:0]  ch_wdata4;
   wire  [31:0] ch_rdata4 = 32'h0;
   wire  [3:0]  ch_ack4   = 4'hF;

   int n_pass  = 0;
   int n_total = 0;
   int req_cnt = 0;
   int oe_cnt  = 0;
   int tout_cnt = 0;
   int base_req, base_oe, base_tout;

   z80_io_port_hub u_dut (
      .clk(clk), .reset_n(reset_n), .A(A), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
      .cd_in(cd_in), .cd_out(cd_out), .cd_oe(cd_oe), .cs_n(cs_n), .ch_req(ch_req),
      .ch_wr(ch_wr), .ch_sub(ch_sub), .ch_wdata(ch_wdata), .ch_rdata(ch_rdata),
      .ch_ack(ch_ack), .timeout(timeout)
   );

   z80_io_port_hub #(
      .NUM_CH(4),
      .CH_BASE({6'h26, 6'h27, 6'h27, 6'h30})
   ) u_dut4 (
      .clk(clk), .reset_n(reset_n), .A(A), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
      .cd_in(cd_in), .cd_out(cd_out4), .cd_oe(cd_oe4), .cs_n(cs_n4), .ch_req(ch_req4),
      .ch_wr(ch_wr4), .ch_sub(ch_sub4), .ch_wdata(ch_wdata4), .ch_rdata(ch_rdata4),
      .ch_ack(ch_ack4), .timeout(timeout4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Event counters sampled mid-cycle.
   always @(negedge clk) begin
      if (ch_req != 2'b00) req_cnt <= req_cnt + 1;
      if (cd_oe)           oe_cnt  <= oe_cnt + 1;
      if (timeout)         tout_cnt <= tout_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic strobes_idle();
      iorq_n = 1'b1;
      rd_n   = 1'b1;
      wr_n   = 1'b1;
   endtask

   initial begin
      reset_n  = 1'b0;
      A        = 8'h00;
      cd_in    = 8'h00;
      ch_rdata = 16'h0000;
      ch_ack   = 2'b00;
      strobes_idle();
      ticks(2);

      // Reset values
      check("rst_cd_out", 32'(cd_out), 32'hFF);
      check("rst_cd_oe", 32'(cd_oe), 32'h0);
      check("rst_cs_n", 32'(cs_n), 32'h1);
      check("rst_ch_req", 32'(ch_req), 32'h0);
      check("rst_ch_wr", 32'(ch_wr), 32'h0);
      check("rst_ch_sub", 32'(ch_sub), 32'h0);
      check("rst_ch_wdata", 32'(ch_wdata), 32'h0);
      check("rst_timeout", 32'(timeout), 32'h0);
      reset_n = 1'b1;
      ticks(3);

      // Write 0x5A to port 0x9D (channel 1, sub 1), ack two cycles after req
      base_req = req_cnt;
      A = 8'h9D; cd_in = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0;
      ticks(2);
      check("wr_no_early_req", 32'(ch_req), 32'h0);
      tick();
      check("wr_req", 32'(ch_req), 32'h2);
      check("wr_ch_wr", 32'(ch_wr), 32'h1);
      check("wr_sub", 32'(ch_sub), 32'h1);
      check("wr_wdata", 32'(ch_wdata), 32'h5A);
      check("wr_cs_n_low", 32'(cs_n), 32'h0);
      tick();
      check("wr_req_width", 32'(ch_req), 32'h0);
      tick();
      ch_ack = 2'b10;
      tick();
      ch_ack = 2'b00;
      strobes_idle();
      tick();
      check("wr_cs_n_hold", 32'(cs_n), 32'h0);
      ticks(2);
      check("wr_cs_n_release", 32'(cs_n), 32'h1);
      check("wr_req_count", 32'(req_cnt - base_req), 32'd1);
      check("wr_no_oe", 32'(oe_cnt), 32'd0);
      ticks(3);

      // Read port 0x98 (channel 0), ack four cycles after req
      ch_rdata = 16'h00C3;
      A = 8'h98; iorq_n = 1'b0; rd_n = 1'b0;
      ticks(3);
      check("rd_req", 32'(ch_req), 32'h1);
      check("rd_ch_wr", 32'(ch_wr), 32'h0);
      check("rd_sub", 32'(ch_sub), 32'h0);
      ticks(4);
      check("rd_oe_before_ack", 32'(cd_oe), 32'h0);
      ch_ack = 2'b01;
      tick();
      ch_ack = 2'b00;
      check("rd_cd_out", 32'(cd_out), 32'hC3);
      check("rd_cd_oe", 32'(cd_oe), 32'h1);
      ticks(2);
      strobes_idle();
      ticks(2);
      check("rd_oe_hold", 32'(cd_oe), 32'h1);
      tick();
      check("rd_oe_drop", 32'(cd_oe), 32'h0);
      ticks(2);
      check("rd_cs_n_release", 32'(cs_n), 32'h1);
      ticks(2);

      // Reset asserted while a read at 0x99 waits for its ack
      A = 8'h99; iorq_n = 1'b0; rd_n = 1'b0;
      ticks(3);
      check("rst_rd_req", 32'(ch_req), 32'h1);
      ticks(2);
      check("rst_pre_cd_out", 32'(cd_out), 32'hC3);
      check("rst_pre_cs_n", 32'(cs_n), 32'h0);
      reset_n = 1'b0;
      #1;
      check("rst_async_cd_out", 32'(cd_out), 32'hFF);
      check("rst_async_cs_n", 32'(cs_n), 32'h1);
      check("rst_async_cd_oe", 32'(cd_oe), 32'h0);
      strobes_idle();
      ticks(2);
      reset_n = 1'b1;
      base_req = req_cnt;
      base_oe  = oe_cnt;
      tick();
      ch_ack = 2'b01;
      tick();
      ch_ack = 2'b00;
      ticks(4);
      check("rst_late_ack_oe", 32'(oe_cnt - base_oe), 32'd0);
      check("rst_late_ack_req", 32'(req_cnt - base_req), 32'd0);
      check("rst_idle_cs_n", 32'(cs_n), 32'h1);

      // Read port 0x9B with no ack: timeout 32 clocks after ch_req
      base_tout = tout_cnt;
      A = 8'h9B; iorq_n = 1'b0; rd_n = 1'b0;
      ticks(3);
      check("to_req", 32'(ch_req), 32'h1);
      check("to_sub", 32'(ch_sub), 32'h3);
      ticks(31);
      check("to_not_yet", 32'(tout_cnt - base_tout), 32'd0);
      check("to_oe_not_yet", 32'(cd_oe), 32'h0);
      tick();
      check("to_pulse", 32'(timeout), 32'h1);
      check("to_cd_out", 32'(cd_out), 32'hFF);
      check("to_cd_oe", 32'(cd_oe), 32'h1);
      tick();
      check("to_pulse_width", 32'(timeout), 32'h0);
      check("to_oe_held", 32'(cd_oe), 32'h1);
      strobes_idle();
      ticks(3);
      check("to_oe_drop", 32'(cd_oe), 32'h0);
      ticks(3);

      // Unmatched port 0xA0
      base_req = req_cnt;
      base_oe  = oe_cnt;
      A = 8'hA0; iorq_n = 1'b0; rd_n = 1'b0;
      ticks(6);
      check("nm_cs_n", 32'(cs_n), 32'h1);
      check("nm_cd_oe", 32'(cd_oe), 32'h0);
      strobes_idle();
      ticks(4);
      check("nm_req_count", 32'(req_cnt - base_req), 32'd0);
      check("nm_oe_count", 32'(oe_cnt - base_oe), 32'd0);

      // Illegal rd_n+wr_n, then a valid write at 0x9E with a level ack
      base_req = req_cnt;
      A = 8'h9D; cd_in = 8'h11; iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
      ticks(6);
      check("ill_no_req", 32'(req_cnt - base_req), 32'd0);
      check("ill_cs_n", 32'(cs_n), 32'h1);
      check("ill_no_req4", 32'(ch_req4), 32'h0);
      strobes_idle();
      ticks(4);
      ch_ack = 2'b10;
      A = 8'h9E; cd_in = 8'hA5; iorq_n = 1'b0; wr_n = 1'b0;
      ticks(3);
      check("b2b_req", 32'(ch_req), 32'h2);
      check("b2b_sub", 32'(ch_sub), 32'h2);
      check("b2b_wdata", 32'(ch_wdata), 32'hA5);
      check("ovl_req4_lowest", 32'(ch_req4), 32'h2);
      check("ovl_wdata4", 32'(ch_wdata4), 32'hA5);
      ticks(6);
      check("b2b_req_count", 32'(req_cnt - base_req), 32'd1);
      strobes_idle();
      ch_ack = 2'b00;
      ticks(4);
      check("b2b_cs_n_release", 32'(cs_n), 32'h1);
      check("b2b_wdata_held", 32'(ch_wdata), 32'hA5);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
